// File: rtl/vram_pixel_reader.sv
// Display-side framebuffer reader: fetches pixel words from the data-memory read port
// into a small prefetch FIFO and streams them out as RGB332 bytes, high byte first.
module vram_pixel_reader #(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h0100,
    parameter int                FRAME_WORDS = 9600,
    parameter int                FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              frame_start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [7:0]        pix_data,
    output logic              frame_end,
    output logic              underrun
);

    localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    typedef enum logic {IDLE, RUN} stateT;

    stateT             state;
    stateT             nextState;
    logic [IDX_W-1:0]  wordIdx;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W:0]    count;
    logic [CNT_W-1:0]  occupancy;
    logic              inflight;
    logic              inflightLast;
    logic              byteSel;
    logic              underrunSticky;
    logic              underrunNow;
    logic              push;
    logic              pop;
    logic              handshake;
    logic [15:0]       headWord;
    logic [15:0]       fifoWord [FIFO_DEPTH];
    logic              fifoLast [FIFO_DEPTH];

    assign pix_valid = (count != '0);
    assign headWord  = fifoWord[rdPtr];
    assign rd_addr   = BASE_ADDR + ADDR_W'(wordIdx);
    assign pix_data  = pix_valid ? (byteSel ? headWord[15:8] : headWord[7:0]) : 8'h00;
    assign frame_end = pop && fifoLast[rdPtr];
    assign underrun  = !frame_start && (underrunSticky || underrunNow);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // frame_start overrides everything this cycle: no new read, no handshake, no push.
    always_comb begin
        nextState   = state;
        rd_en       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        handshake   = 1'b0;
        underrunNow = 1'b0;
        occupancy   = CNT_W'(count) + CNT_W'(inflight);
        if (frame_start) begin
            nextState = RUN;
        end
        if (state == RUN && enable && !frame_start && occupancy < CNT_W'(FIFO_DEPTH)) begin
            rd_en = 1'b1;
        end
        push        = inflight && !frame_start;
        handshake   = pix_valid && pix_ready && !frame_start;
        pop         = handshake && !byteSel;
        underrunNow = (state == RUN) && pix_ready && !pix_valid && !frame_start;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wordIdx      <= '0;
            inflight     <= 1'b0;
            inflightLast <= 1'b0;
        end else begin
            inflight     <= rd_en;
            inflightLast <= rd_en && (wordIdx == LAST_IDX);
            if (frame_start) begin
                wordIdx <= '0;
            end else if (rd_en) begin
                wordIdx <= (wordIdx == LAST_IDX) ? '0 : wordIdx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            byteSel <= 1'b1;
        end else if (frame_start) begin
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            byteSel <= 1'b1;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            if (handshake) begin
                byteSel <= ~byteSel;
            end
        end
    end

    // Tag each word with whether it is the last of the frame so frame_end needs no counter.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoWord[wrPtr] <= rd_data;
            fifoLast[wrPtr] <= inflightLast;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrunSticky <= 1'b0;
        end else if (frame_start) begin
            underrunSticky <= 1'b0;
        end else if (underrunNow) begin
            underrunSticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vram_pixel_reader.sv
// Bench for vram_pixel_reader: directed scenarios plus randomized handshakes, checked
// against a word/pixel counting model of the fetch and output streams.
module tb_vram_pixel_reader;

    localparam int          FW    = 8;
    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'h0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_ready = 1'b0;
    logic [15:0] rd_data;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        frame_end;
    logic        underrun;

    logic [15:0] mem [0:511];

    int vectors = 0;
    int miscompares = 0;
    int issued, accepted, prevIssued, lastIssuedIdx;
    bit run, sticky;
    bit idx5Seen;

    always #5 clk = ~clk;

    vram_pixel_reader #(
        .ADDR_W(16), .BASE_ADDR(BASE), .FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .frame_end(frame_end), .underrun(underrun)
    );

    // Memory answers one cycle after a request; garbage otherwise exposes mistimed pushes.
    always @(posedge clk) begin
        rd_data <= rd_en ? mem[rd_addr[8:0]] : 16'($urandom);
    end

    function automatic logic [7:0] expPix(input int n);
        logic [15:0] w;
        w = mem[int'(BASE) + (n / 2) % FW];
        return (n % 2 == 0) ? w[15:8] : w[7:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: inputs are already stable; outputs are judged at the falling edge.
    task automatic tick();
        int  expRd;
        bit  expValid;
        @(negedge clk);
        lastIssuedIdx = -1;
        if (!run || !rst) begin
            checkOutput("idle_rd_en", rd_en, 0);
            checkOutput("idle_rd_addr", rd_addr, BASE);
            checkOutput("idle_pix_valid", pix_valid, 0);
            checkOutput("idle_pix_data", pix_data, 0);
            checkOutput("idle_frame_end", frame_end, 0);
            checkOutput("idle_underrun", underrun, 0);
        end else if (frame_start) begin
            checkOutput("fs_frame_end", frame_end, 0);
            checkOutput("fs_underrun", underrun, 0);
        end else begin
            expRd = (enable && (issued - accepted / 2 < DEPTH)) ? 1 : 0;
            checkOutput("rd_en", rd_en, expRd);
            if (expRd != 0) begin
                checkOutput("rd_addr", rd_addr, int'(BASE) + issued % FW);
                lastIssuedIdx = issued % FW;
            end
            expValid = (prevIssued * 2 > accepted);
            checkOutput("pix_valid", pix_valid, expValid);
            prevIssued = issued;
            if (expRd != 0) issued++;
            if (expValid && pix_ready) begin
                checkOutput("pix_data", pix_data, expPix(accepted));
                checkOutput("frame_end", frame_end, (accepted % (2 * FW)) == 2 * FW - 1);
                accepted++;
            end else begin
                checkOutput("frame_end_quiet", frame_end, 0);
            end
            if (pix_ready && !expValid) sticky = 1'b1;
            checkOutput("underrun", underrun, sticky);
        end
        if (rst && frame_start) begin
            run = 1'b1; issued = 0; accepted = 0; prevIssued = 0; sticky = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit fs, input bit en, input bit rdy);
        frame_start = fs;
        enable      = en;
        pix_ready   = rdy;
        tick();
        frame_start = 1'b0;
    endtask

    // Drops reset between clock edges and confirms outputs fall without waiting for clk.
    task automatic dropReset();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rd_en", rd_en, 0);
        checkOutput("async_pix_valid", pix_valid, 0);
        checkOutput("async_rd_addr", rd_addr, BASE);
        run = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
        mem[256] = 16'hA5C3;
        mem[261] = 16'hDEAD;
        run = 1'b0; sticky = 1'b0; issued = 0; accepted = 0; prevIssued = 0;

        $display("[TB] reset and idle");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1);

        $display("[TB] first frame, continuous ready");
        applyStimulus(1, 1, 1);
        for (int i = 0; i < 40; i++) applyStimulus(0, 1, 1);

        $display("[TB] backpressure");
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 1);

        $display("[TB] underrun with enable low");
        dropReset();
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1);
        rst = 1'b1;
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1);
        applyStimulus(1, 1, 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1);

        $display("[TB] restart with a read in flight");
        applyStimulus(1, 1, 1);
        idx5Seen = 1'b0;
        for (int i = 0; i < 60 && !idx5Seen; i++) begin
            applyStimulus(0, 1, 1);
            if (lastIssuedIdx == 5) idx5Seen = 1'b1;
        end
        checkOutput("idx5_issued", idx5Seen, 1);
        applyStimulus(1, 1, 1);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 1);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1);
        dropReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1);
        applyStimulus(1, 1, 1);

        $display("[TB] randomized handshakes");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0,
                          $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
